// File: rtl/framebuffer_scanner.sv
// Read-side sequencer for a 1-cycle-latency frame RAM: sweeps addresses 0..DEPTH-1
// and streams the words out as a valid/ready pixel stream through a 2-entry skid FIFO.
module framebuffer_scanner #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [$clog2(DEPTH)-1:0]   raddr,
  input  logic [SIZE-1:0]            read_data,
  output logic [SIZE-1:0]            pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_first,
  output logic                       pix_last,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_raddr;
  logic            r_inflight;
  logic            r_inf_first;
  logic            r_inf_last;
  logic [SIZE-1:0] r_fifo_data [2];
  logic [1:0]      r_fifo_first;
  logic [1:0]      r_fifo_last;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic            r_frame_done;

  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_occ;
  logic            w_issue;
  logic            w_addr_last;
  logic            w_head_last;
  logic            w_last_xfer;

  // Issue only while words in the FIFO plus the one in flight leave room after this pop.
  assign w_pop       = (r_count != 2'd0) & pix_ready;
  assign w_push      = r_inflight;
  assign w_occ       = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue     = (r_state == S_SCAN) & (w_occ < 3'd2);
  assign w_addr_last = (r_raddr == AW'(DEPTH - 1));
  assign w_head_last = r_fifo_last[r_rd_ptr];
  assign w_last_xfer = w_pop & w_head_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_SCAN;
        S_SCAN:  if (w_issue && w_addr_last) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_last_xfer) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Address sweep, in-flight tracking and the 2-entry output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr      <= '0;
      r_inflight   <= 1'b0;
      r_inf_first  <= 1'b0;
      r_inf_last   <= 1'b0;
      r_fifo_first <= '0;
      r_fifo_last  <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
    end else if (abort) begin
      r_raddr      <= '0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == S_DRAIN) & w_last_xfer;
      r_inflight   <= w_issue;
      if (w_issue) begin
        r_inf_first <= (r_raddr == '0);
        r_inf_last  <= w_addr_last;
        // Wrap to 0 after the final issue so raddr never leaves the frame range.
        r_raddr     <= w_addr_last ? '0 : AW'(r_raddr + AW'(1));
      end
      if (w_push) begin
        r_fifo_data[r_wr_ptr]  <= read_data;
        r_fifo_first[r_wr_ptr] <= r_inf_first;
        r_fifo_last[r_wr_ptr]  <= r_inf_last;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= 2'(r_count + 2'(w_push) - 2'(w_pop));
    end
  end

  assign raddr      = r_raddr;
  assign pix_valid  = (r_count != 2'd0);
  assign pix_data   = r_fifo_data[r_rd_ptr];
  assign pix_first  = pix_valid & r_fifo_first[r_rd_ptr];
  assign pix_last   = pix_valid & w_head_last;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule
